sevenseg_reader: RTL and testbench

//  Reads a 7-segment display bus ({a,b,c,d,e,f,g}) and recovers the displayed digit as 4-bit BCD.

---
 rtl/sevenseg_reader.sv | 185 ++++++++++++++++++
 tb/tb_sevenseg_reader.sv | 212 +++++++++++++++++++++
 2 files changed

// File: rtl/sevenseg_reader.sv
// 7-segment bus -> BCD reader: sync, debounce, decode, 2-entry FIFO. Hex letters with SEVENSEG_READER_HEX_EN.
// Latency STABLE_CYCLES+2 clk from stable pattern to out_valid; FIFO full with no pop drops and flags err_overrun.
module sevenseg_reader #(
    parameter int STABLE_CYCLES  = 16,
    parameter bit SEG_ACTIVE_LOW = 1'b1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [6:0] seg_in,
    output logic [3:0] out_digit,
    output logic       out_bad,
    output logic       out_valid,
    input  logic       out_ready,
    output logic       err_overrun,
    input  logic       clr_err
);

    localparam int             CW        = $clog2(STABLE_CYCLES);
    localparam logic [CW-1:0]  CNT_LAST  = CW'(STABLE_CYCLES - 1);
    localparam logic [CW-1:0]  CNT_ONE   = CW'(1);
    localparam logic [6:0]     SYNC_IDLE = SEG_ACTIVE_LOW ? 7'h7F : 7'h00;

    typedef enum logic {
        ST_TRACK   = 1'b0,
        ST_SETTLED = 1'b1
    } state_t;

    logic [6:0]    r_sync1;
    logic [6:0]    r_sync2;
    logic [6:0]    w_lit;

    state_t        r_state;
    state_t        w_state_nxt;
    logic [6:0]    r_cand;
    logic [6:0]    w_cand_nxt;
    logic [CW-1:0] r_cnt;
    logic [CW-1:0] w_cnt_nxt;
    logic [6:0]    r_last_emit;
    logic [6:0]    w_last_nxt;
    logic          w_push;
    logic [4:0]    w_dec;

    logic [4:0]    r_head_dat;
    logic [4:0]    r_tail_dat;
    logic          r_head_vld;
    logic          r_tail_vld;
    logic          r_overrun;
    logic          w_pop;
    logic          w_drop;

    function automatic logic [4:0] decode_lit(input logic [6:0] lit);
        logic [4:0] res;
        case (lit)
            7'h7E:   res = {1'b0, 4'h0};
            7'h30:   res = {1'b0, 4'h1};
            7'h6D:   res = {1'b0, 4'h2};
            7'h79:   res = {1'b0, 4'h3};
            7'h33:   res = {1'b0, 4'h4};
            7'h5B:   res = {1'b0, 4'h5};
            7'h5F:   res = {1'b0, 4'h6};
            7'h70:   res = {1'b0, 4'h7};
            7'h72:   res = {1'b0, 4'h7};
            7'h7F:   res = {1'b0, 4'h8};
            7'h7B:   res = {1'b0, 4'h9};
            7'h73:   res = {1'b0, 4'h9};
`ifdef SEVENSEG_READER_HEX_EN
            // 1F is claimed by lowercase b here, so 6 only decodes from 5F
            7'h77:   res = {1'b0, 4'hA};
            7'h1F:   res = {1'b0, 4'hB};
            7'h4E:   res = {1'b0, 4'hC};
            7'h3D:   res = {1'b0, 4'hD};
            7'h4F:   res = {1'b0, 4'hE};
            7'h47:   res = {1'b0, 4'hF};
`else
            7'h1F:   res = {1'b0, 4'h6};
`endif
            default: res = {1'b1, 4'hF};
        endcase
        return res;
    endfunction

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_sync1 <= SYNC_IDLE;
            r_sync2 <= SYNC_IDLE;
        end else begin
            r_sync1 <= seg_in;
            r_sync2 <= r_sync1;
        end
    end

    assign w_lit = SEG_ACTIVE_LOW ? ~r_sync2 : r_sync2;
    assign w_dec = decode_lit(r_cand);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state     <= ST_TRACK;
            r_cand      <= 7'h00;
            r_cnt       <= '0;
            r_last_emit <= 7'h00;
        end else begin
            r_state     <= w_state_nxt;
            r_cand      <= w_cand_nxt;
            r_cnt       <= w_cnt_nxt;
            r_last_emit <= w_last_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cand_nxt  = r_cand;
        w_cnt_nxt   = r_cnt;
        w_last_nxt  = r_last_emit;
        w_push      = 1'b0;
        if (w_lit != r_cand) begin
            w_state_nxt = ST_TRACK;
            w_cand_nxt  = w_lit;
            w_cnt_nxt   = CNT_ONE;
        end else begin
            if (r_cnt != CNT_LAST) begin
                w_cnt_nxt = r_cnt + CNT_ONE;
            end
            if (r_state == ST_TRACK && r_cnt == CNT_LAST) begin
                w_state_nxt = ST_SETTLED;
                // Blank re-arms emission so a repeated digit is reported again
                if (r_cand == 7'h00) begin
                    w_last_nxt = 7'h00;
                end else if (r_cand != r_last_emit) begin
                    w_push     = 1'b1;
                    w_last_nxt = r_cand;
                end
            end
        end
    end

    assign w_pop  = r_head_vld && out_ready;
    assign w_drop = w_push && !w_pop && r_tail_vld;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_head_dat <= 5'h00;
            r_tail_dat <= 5'h00;
            r_head_vld <= 1'b0;
            r_tail_vld <= 1'b0;
        end else if (w_pop) begin
            if (r_tail_vld) begin
                r_head_dat <= r_tail_dat;
                if (w_push) begin
                    r_tail_dat <= w_dec;
                end else begin
                    r_tail_vld <= 1'b0;
                end
            end else if (w_push) begin
                r_head_dat <= w_dec;
            end else begin
                r_head_vld <= 1'b0;
            end
        end else if (w_push) begin
            if (!r_head_vld) begin
                r_head_dat <= w_dec;
                r_head_vld <= 1'b1;
            end else if (!r_tail_vld) begin
                r_tail_dat <= w_dec;
                r_tail_vld <= 1'b1;
            end
        end
    end

    // A new overrun outranks a clear arriving in the same cycle
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_overrun <= 1'b0;
        end else if (w_drop) begin
            r_overrun <= 1'b1;
        end else if (clr_err) begin
            r_overrun <= 1'b0;
        end
    end

    assign out_digit   = r_head_dat[3:0];
    assign out_bad     = r_head_dat[4];
    assign out_valid   = r_head_vld;
    assign err_overrun = r_overrun;

endmodule

// File: tb/tb_sevenseg_reader.sv
// Directed bench for sevenseg_reader (default parameters, active-low segment lines).
module tb_sevenseg_reader;

    logic       clk = 1'b0;
    logic       rst_n;
    logic [6:0] seg_in;
    logic [3:0] out_digit;
    logic       out_bad;
    logic       out_valid;
    logic       out_ready;
    logic       err_overrun;
    logic       clr_err;

    int checks   = 0;
    int failures = 0;
    int cyc      = 0;
    int beats    = 0;
    int beat_cyc = 0;
    logic [4:0] exp_q[$];

    sevenseg_reader dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .seg_in     (seg_in),
        .out_digit  (out_digit),
        .out_bad    (out_bad),
        .out_valid  (out_valid),
        .out_ready  (out_ready),
        .err_overrun(err_overrun),
        .clr_err    (clr_err)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc++;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] expv);
        checks++;
        assert (obs === expv) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n === 1'b1 && out_valid === 1'b1 && out_ready === 1'b1) begin
            logic [4:0] e;
            beats++;
            beat_cyc = cyc;
            chk("beat_expected", exp_q.size() > 0, 1);
            if (exp_q.size() > 0) begin
                e = exp_q.pop_front();
                chk("beat_dat", {27'b0, out_bad, out_digit}, {27'b0, e});
            end
        end
    end

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic show_lit(input logic [6:0] lit, input int n);
        seg_in = ~lit;
        step(n);
    endtask

    localparam int NPAT = 15;
    logic [6:0] pat_lit [NPAT] = '{7'h7E, 7'h30, 7'h6D, 7'h79, 7'h33, 7'h5B, 7'h5F, 7'h70,
                                   7'h7F, 7'h7B, 7'h1F, 7'h72, 7'h73, 7'h01, 7'h4E};
`ifdef SEVENSEG_READER_HEX_EN
    logic [4:0] pat_exp [NPAT] = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07,
                                   5'h08, 5'h09, 5'h0B, 5'h07, 5'h09, 5'h1F, 5'h0C};
    localparam logic [4:0] EXP_77 = 5'h0A;
`else
    logic [4:0] pat_exp [NPAT] = '{5'h00, 5'h01, 5'h02, 5'h03, 5'h04, 5'h05, 5'h06, 5'h07,
                                   5'h08, 5'h09, 5'h06, 5'h07, 5'h09, 5'h1F, 5'h1F};
    localparam logic [4:0] EXP_77 = 5'h1F;
`endif

    initial begin
        int b0;
        int chg_cyc;

        rst_n     = 1'b0;
        seg_in    = 7'h7F;
        out_ready = 1'b1;
        clr_err   = 1'b0;
        step(3);
        chk("rst_valid", out_valid, 0);
        chk("rst_digit", out_digit, 0);
        chk("rst_bad", out_bad, 0);
        chk("rst_overrun", err_overrun, 0);
        rst_n = 1'b1;

        // Single digit and its latency
        b0 = beats;
        exp_q.push_back(5'h00);
        seg_in  = 7'h01;
        chg_cyc = cyc;
        step(25);
        chk("t1_beats", beats - b0, 1);
        chk("t1_latency", beat_cyc - chg_cyc, 18);
        chk("t1_q_empty", exp_q.size(), 0);

        // Short-lived 3 is never accepted, 8 is
        b0 = beats;
        exp_q.push_back(5'h08);
        seg_in = 7'h06;
        step(10);
        seg_in = 7'h00;
        step(25);
        chk("t2_beats", beats - b0, 1);
        chk("t2_q_empty", exp_q.size(), 0);

        // Repeated 5 separated by blank, then glitch suppression
        b0 = beats;
        exp_q.push_back(5'h05);
        exp_q.push_back(5'h05);
        seg_in = 7'h24;
        step(25);
        seg_in = 7'h7F;
        step(20);
        seg_in = 7'h24;
        step(25);
        chk("t3_beats", beats - b0, 2);
        b0 = beats;
        seg_in = 7'h00;
        step(5);
        seg_in = 7'h24;
        step(25);
        chk("t3_glitch_beats", beats - b0, 0);
        chk("t3_q_empty", exp_q.size(), 0);

        // Letter A pattern
        b0 = beats;
        show_lit(7'h00, 20);
        exp_q.push_back(EXP_77);
        seg_in = 7'h08;
        step(25);
        chk("t4_beats", beats - b0, 1);
        chk("t4_q_empty", exp_q.size(), 0);

        // Decode table sweep, each pattern preceded by blank
        b0 = beats;
        for (int i = 0; i < NPAT; i++) begin
            show_lit(7'h00, 20);
            exp_q.push_back(pat_exp[i]);
            show_lit(pat_lit[i], 22);
        end
        chk("sweep_beats", beats - b0, NPAT);
        chk("sweep_q_empty", exp_q.size(), 0);

        // Overrun with consumer stalled
        out_ready = 1'b0;
        b0 = beats;
        show_lit(7'h00, 20);
        exp_q.push_back(5'h01);
        show_lit(7'h30, 22);
        show_lit(7'h00, 20);
        exp_q.push_back(5'h02);
        show_lit(7'h6D, 22);
        chk("t5_no_overrun_yet", err_overrun, 0);
        show_lit(7'h00, 20);
        show_lit(7'h79, 22);
        chk("t5_overrun", err_overrun, 1);
        chk("t5_valid_held", out_valid, 1);
        chk("t5_head_digit", out_digit, 1);
        chk("t5_head_bad", out_bad, 0);
        chk("t5_stall_beats", beats - b0, 0);
        clr_err = 1'b1;
        step(1);
        clr_err = 1'b0;
        chk("t5_clr", err_overrun, 0);
        out_ready = 1'b1;
        step(4);
        chk("t5_drain_beats", beats - b0, 2);
        chk("t5_q_empty", exp_q.size(), 0);
        chk("t5_empty_valid", out_valid, 0);

        // Reset with FIFO full, overrun set and a pattern mid-count
        out_ready = 1'b0;
        show_lit(7'h00, 20);
        show_lit(7'h33, 22);
        show_lit(7'h00, 20);
        show_lit(7'h5B, 22);
        show_lit(7'h00, 20);
        show_lit(7'h5F, 22);
        chk("t6_pre_overrun", err_overrun, 1);
        chk("t6_pre_valid", out_valid, 1);
        show_lit(7'h70, 8);
        rst_n = 1'b0;
        #1;
        chk("t6_rst_valid", out_valid, 0);
        chk("t6_rst_overrun", err_overrun, 0);
        chk("t6_rst_digit", out_digit, 0);
        exp_q.delete();
        step(2);
        seg_in    = 7'h7F;
        rst_n     = 1'b1;
        out_ready = 1'b1;
        b0 = beats;
        step(40);
        chk("t6_no_stale", beats - b0, 0);
        chk("t6_valid_after", out_valid, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
